// File: rtl/norm_channel_scheduler.sv
// Round-robin sharing of one re/im normalization unit between NUM_CH channels.
// Buffers one pair per channel, tags issues with their channel and re-associates returns.
module norm_channel_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = $clog2(NUM_CH),
  parameter int unsigned NORM_LAT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [32*NUM_CH-1:0] ch_re,
  input  logic [32*NUM_CH-1:0] ch_im,
  input  logic                 ovf_clr,
  output logic [31:0]          norm_re,
  output logic [31:0]          norm_im,
  output logic                 norm_en,
  input  logic [31:0]          norm_re_res,
  input  logic                 norm_re_res_en,
  input  logic [31:0]          norm_im_res,
  input  logic                 norm_im_res_en,
  output logic [31:0]          out_re,
  output logic [31:0]          out_im,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_valid,
  output logic [NUM_CH-1:0]    ovf,
  output logic                 sync_err,
  output logic                 busy
);

  localparam int unsigned FL_W = $clog2(NORM_LAT + 1);

  logic [31:0]       r_re_hold [NUM_CH];
  logic [31:0]       r_im_hold [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_issue_ch;
  logic [NORM_LAT-1:0] r_tag_v;
  logic [CH_W-1:0]   r_tag_ch [NORM_LAT];
  logic [FL_W-1:0]   r_flush;

  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic [NUM_CH-1:0] w_keep;
  logic [NUM_CH-1:0] w_cap;
  logic [NUM_CH-1:0] w_ovf_set;
  logic              w_live;
  logic              w_sync_set;
  int                w_idx;

  // First pending channel at or above rr_ptr, with wrap; lowest offset wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= int'(NUM_CH)) w_idx = w_idx - int'(NUM_CH);
      if (r_pend[CH_W'(w_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CH_W'(w_idx);
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + CH_W'(1);
  assign w_gnt_oh  = w_gnt_vld ? (NUM_CH'(1) << w_gnt_ch) : '0;
  // A pair is kept (and a new arrival dropped) only if pending and not issued now.
  assign w_keep    = r_pend & ~w_gnt_oh;
  assign w_cap     = ch_valid & ~w_keep;
  assign w_ovf_set = ch_valid & w_keep;

  assign w_live     = (r_flush == '0);
  assign w_sync_set = w_live & ((norm_re_res_en != norm_im_res_en) ||
                                (norm_re_res_en != r_tag_v[NORM_LAT-1]));

  assign busy = (|r_pend) | (|r_tag_v) | norm_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_re_hold[i] <= '0;
        r_im_hold[i] <= '0;
      end
      for (int i = 0; i < int'(NORM_LAT); i++) r_tag_ch[i] <= '0;
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_issue_ch <= '0;
      r_tag_v    <= '0;
      r_flush    <= FL_W'(NORM_LAT);
      norm_re    <= '0;
      norm_im    <= '0;
      norm_en    <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      ovf        <= '0;
      sync_err   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (w_cap[i]) begin
          r_re_hold[i] <= ch_re[32*i +: 32];
          r_im_hold[i] <= ch_im[32*i +: 32];
        end
      end
      r_pend <= ch_valid | w_keep;

      norm_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        norm_re    <= r_re_hold[w_gnt_ch];
        norm_im    <= r_im_hold[w_gnt_ch];
        r_issue_ch <= w_gnt_ch;
        r_rr_ptr   <= w_ptr_nxt;
      end

      // Tag line mirrors the unit's fixed latency.
      r_tag_v     <= {r_tag_v[NORM_LAT-2:0], norm_en};
      r_tag_ch[0] <= r_issue_ch;
      for (int i = 1; i < int'(NORM_LAT); i++) r_tag_ch[i] <= r_tag_ch[i-1];

      if (!w_live) r_flush <= r_flush - FL_W'(1);

      out_valid <= w_live & norm_re_res_en;
      if (w_live && norm_re_res_en) begin
        out_re <= norm_re_res;
        out_im <= norm_im_res;
        out_ch <= r_tag_ch[NORM_LAT-1];
      end

      ovf      <= (ovf_clr ? '0 : ovf) | w_ovf_set;
      sync_err <= (sync_err & ~ovf_clr) | w_sync_set;
    end
  end

endmodule
